mc_ctrl_seq: RTL and testbench

// Multi-cycle MIPS control unit with its own phase sequencer.
// - Holds the phase state internally rather than decoding an externally driven phase.
// - Skips phases an instruction does not use.
// - Stalls on the memory handshake.
// - Flags illegal opcodes and counts retired instructions.
// - Sits between the IR/datapath muxes and the unified memory port.

---
 rtl/mc_ctrl_seq.sv | 212 +++++++++++++++++++++
 tb/tb_mc_ctrl_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq -- multi-cycle MIPS control unit with built-in phase sequencer.
//
// Walks FETCH(P0) -> DECODE(P1) -> EXEC(P2) -> MEM(P3) -> WB(P4) and skips
// the phases an instruction class does not use. It waits in P0/P3 on the
// memory handshake, flags undecodable instructions and counts retirements.
//
// Optional feature macro: MC_STALL_CNT_EN. When it is defined, stall_cnt
// counts the P0/P3 cycles with mem_ready low. When it is undefined,
// stall_cnt is tied to 0 and no counter register is built.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   op, irfunc          IR[31:26], IR[5:0]
//   mem_ready           memory access completes this cycle
//   phase               one-hot current phase (bit n = Pn)
//   lorD .. pccond      datapath / memory control strobes and mux selects
//   illegal             one-cycle pulse after decoding an illegal instruction
//   retired, stall_cnt  free-running wrap-around counters
module mc_ctrl_seq #(
    parameter int OP_W    = 6,
    parameter int SEL_W   = 4,
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [OP_W-1:0]    irfunc,
    input  logic               mem_ready,
    output logic [4:0]         phase,
    output logic [1:0]         lorD,
    output logic [SEL_W-1:0]   RegDst,
    output logic [SEL_W-1:0]   MemtoReg,
    output logic [1:0]         AluSrcA,
    output logic [SEL_W-1:0]   AluSrcB,
    output logic [SEL_W-1:0]   PCSource,
    output logic               PCWrite,
    output logic               ImemWrite,
    output logic               pcinc,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               regwrite,
    output logic               memWrite,
    output logic [1:0]         shiftSrc,
    output logic               pccond,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [2:0] {
        S_P0 = 3'd0, S_P1 = 3'd1, S_P2 = 3'd2, S_P3 = 3'd3, S_P4 = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ILL = 3'd0, C_ADD = 3'd1, C_LW = 3'd2, C_SW = 3'd3,
        C_J   = 3'd4, C_JAL = 3'd5, C_BEQ = 3'd6, C_BNE = 3'd7
    } cls_t;

    localparam logic [SEL_W-1:0]   SEL_1     = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0]   SEL_2     = SEL_W'(4'b0010);
    localparam logic [SEL_W-1:0]   SEL_4     = SEL_W'(4'b0100);
    localparam logic [SEL_W-1:0]   SEL_8     = SEL_W'(4'b1000);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(6'b000010);
    localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(6'b100011);
    localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(6'b100001);

    state_t state, state_nx;
    cls_t   cls, dec_cls;
    logic   retire;

    // Instruction decode. Only consumed in P1; the result is latched into
    // cls on the P1 edge, so later IR changes do not affect the instruction.
    always_comb begin
        dec_cls = C_ILL;
        if (op == OP_W'(6'b000000) && irfunc == OP_W'(6'b100000)) dec_cls = C_ADD;
        else if (op == OP_W'(6'b100011)) dec_cls = C_LW;
        else if (op == OP_W'(6'b101011)) dec_cls = C_SW;
        else if (op == OP_W'(6'b000010)) dec_cls = C_J;
        else if (op == OP_W'(6'b000011)) dec_cls = C_JAL;
        else if (op == OP_W'(6'b000100)) dec_cls = C_BEQ;
        else if (op == OP_W'(6'b000101)) dec_cls = C_BNE;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_P0;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_P0: if (mem_ready) state_nx = S_P1;
            S_P1: state_nx = (dec_cls == C_ILL) ? S_P0 : S_P2;
            S_P2: begin
                unique case (cls)
                    C_ADD, C_JAL: state_nx = S_P4;
                    C_LW, C_SW:   state_nx = S_P3;
                    default:      state_nx = S_P0;
                endcase
            end
            S_P3: if (mem_ready) state_nx = (cls == C_LW) ? S_P4 : S_P0;
            S_P4: state_nx = S_P0;
            default: state_nx = S_P0;
        endcase
    end

    // Output logic. The IR is itself a register, so the P1 branch-target
    // setup taken from the live decode is still registered-sourced.
    always_comb begin
        phase     = 5'b00001 << state;
        lorD      = 2'b00;
        RegDst    = '0;
        MemtoReg  = '0;
        AluSrcA   = 2'b00;
        AluSrcB   = '0;
        PCSource  = '0;
        PCWrite   = 1'b0;
        ImemWrite = 1'b0;
        pcinc     = 1'b0;
        AluOp     = '0;
        regwrite  = 1'b0;
        memWrite  = 1'b0;
        shiftSrc  = 2'b00;
        pccond    = 1'b0;
        unique case (state)
            S_P0: begin
                lorD      = 2'b01;
                // mem_ready is live, so reset has to mask the IR load itself
                ImemWrite = mem_ready & ~reset;
            end
            S_P1: begin
                pcinc = 1'b1;
                if (dec_cls == C_BEQ || dec_cls == C_BNE) begin
                    AluSrcA  = 2'b01;
                    AluSrcB  = SEL_8;
                    AluOp    = ALU_ADD;
                    shiftSrc = 2'b01;
                end
            end
            S_P2: begin
                unique case (cls)
                    C_ADD: begin
                        AluSrcA = 2'b10;
                        AluSrcB = SEL_1;
                        AluOp   = ALU_ADD;
                    end
                    C_LW, C_SW: begin
                        AluSrcA  = 2'b10;
                        AluSrcB  = SEL_8;
                        AluOp    = ALU_ADD;
                        shiftSrc = 2'b01;
                    end
                    C_BEQ, C_BNE: begin
                        AluSrcA  = 2'b10;
                        AluSrcB  = SEL_1;
                        PCSource = SEL_2;
                        pccond   = 1'b1;
                        AluOp    = (cls == C_BEQ) ? ALU_BEQ : ALU_BNE;
                    end
                    C_J, C_JAL: begin
                        PCSource = SEL_4;
                        shiftSrc = 2'b10;
                        PCWrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_P3: begin
                lorD     = 2'b10;
                memWrite = (cls == C_SW);
            end
            S_P4: begin
                regwrite = 1'b1;
                unique case (cls)
                    C_ADD: begin RegDst = SEL_2; MemtoReg = SEL_1; end
                    C_LW:  begin RegDst = SEL_1; MemtoReg = SEL_2; end
                    C_JAL: begin RegDst = SEL_4; MemtoReg = SEL_4; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Every return to P0 retires an instruction except the illegal P1 exit
    assign retire = (state_nx == S_P0) && (state != S_P0) && (state != S_P1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls     <= C_ILL;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (state == S_P1) cls <= dec_cls;
            illegal <= (state == S_P1) && (dec_cls == C_ILL);
            if (retire) retired <= retired + 1'b1;
        end
    end

`ifdef MC_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt <= '0;
        else if ((state == S_P0 || state == S_P3) && !mem_ready)
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Self-checking bench for mc_ctrl_seq: per-cycle expected control words are
// queued when a cycle is driven and compared when that cycle is sampled.
module tb_mc_ctrl_seq;
    localparam int ADD = 0, LW = 1, SW = 2, J = 3, JAL = 4, BEQ = 5, BNE = 6, ILL = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, irfunc;
    logic        mem_ready;
    logic [4:0]  phase;
    logic [1:0]  lorD, AluSrcA, shiftSrc;
    logic [3:0]  RegDst, MemtoReg, AluSrcB, PCSource;
    logic        PCWrite, ImemWrite, pcinc, regwrite, memWrite, pccond, illegal;
    logic [5:0]  AluOp;
    logic [31:0] retired, stall_cnt;

    mc_ctrl_seq dut (
        .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .mem_ready(mem_ready),
        .phase(phase), .lorD(lorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .ImemWrite(ImemWrite), .pcinc(pcinc), .AluOp(AluOp),
        .regwrite(regwrite), .memWrite(memWrite), .shiftSrc(shiftSrc),
        .pccond(pccond), .illegal(illegal), .retired(retired), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int          errs = 0, checks = 0;
    int          ret_m = 0, stall_m = 0;
    bit          ill_pend = 1'b0;
    logic [39:0] sb[$];
    logic [39:0] obs;

    assign obs = {phase, lorD, RegDst, MemtoReg, AluSrcA, AluSrcB, PCSource,
                  PCWrite, ImemWrite, pcinc, AluOp, regwrite, memWrite,
                  shiftSrc, pccond, illegal};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Expected control word for one cycle, straight from the output table
    function automatic logic [39:0] expv(input int ph, input int cls, input logic mr, input logic ill);
        logic [4:0] phs;
        logic [1:0] lo, asa, ss;
        logic [3:0] rd, mtr, asb, pcs;
        logic       pw, iw, pi, rw, mw, pc;
        logic [5:0] aop;
        phs = 5'b00001 << ph;
        lo = 0; asa = 0; ss = 0; rd = 0; mtr = 0; asb = 0; pcs = 0;
        pw = 0; iw = 0; pi = 0; rw = 0; mw = 0; pc = 0; aop = 0;
        case (ph)
            0: begin lo = 2'b01; iw = mr; end
            1: begin
                pi = 1;
                if (cls == BEQ || cls == BNE) begin
                    asa = 2'b01; asb = 4'b1000; aop = 6'b000010; ss = 2'b01;
                end
            end
            2: case (cls)
                ADD: begin asa = 2'b10; asb = 4'b0001; aop = 6'b000010; end
                LW, SW: begin asa = 2'b10; asb = 4'b1000; aop = 6'b000010; ss = 2'b01; end
                BEQ, BNE: begin
                    asa = 2'b10; asb = 4'b0001; pcs = 4'b0010; pc = 1;
                    aop = (cls == BEQ) ? 6'b100011 : 6'b100001;
                end
                default: begin pcs = 4'b0100; ss = 2'b10; pw = 1; end
            endcase
            3: begin lo = 2'b10; mw = (cls == SW); end
            default: begin
                rw = 1;
                case (cls)
                    ADD: begin rd = 4'b0010; mtr = 4'b0001; end
                    LW:  begin rd = 4'b0001; mtr = 4'b0010; end
                    default: begin rd = 4'b0100; mtr = 4'b0100; end
                endcase
            end
        endcase
        return {phs, lo, rd, mtr, asa, asb, pcs, pw, iw, pi, aop, rw, mw, ss, pc, ill};
    endfunction

    // One clock cycle: queue the expectation, compare at negedge, advance
    task automatic step(input int ph, input int cls, input logic mr);
        mem_ready = mr;
        sb.push_back(expv(ph, cls, mr, ill_pend));
        ill_pend = 1'b0;
        @(negedge clk);
        chk($sformatf("ph%0d_cls%0d", ph, cls), 64'(obs), 64'(sb.pop_front()));
        if (!mr && (ph == 0 || ph == 3)) stall_m++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt();
        chk("retired", 64'(retired), 64'(ret_m));
`ifdef MC_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`else
        chk("stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int cls,
                            input int fw, input int mw);
        op = o; irfunc = f;
        for (int i = 0; i < fw; i++) step(0, cls, 1'b0);
        step(0, cls, 1'b1);
        step(1, cls, 1'b0);
        // IR changes after decode must not disturb the latched class
        op = 6'b000010; irfunc = 6'b111111;
        if (cls == ILL) begin
            ill_pend = 1'b1;
        end else begin
            step(2, cls, 1'b0);
            if (cls == LW || cls == SW) begin
                for (int i = 0; i < mw; i++) step(3, cls, 1'b0);
                step(3, cls, 1'b1);
            end
            if (cls == ADD || cls == LW || cls == JAL) step(4, cls, 1'b0);
            ret_m++;
        end
        chk_cnt();
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; op = '0; irfunc = '0;
        #2;
        // ImemWrite must stay low under reset even with mem_ready high
        chk("reset_word", 64'(obs), 64'(expv(0, ADD, 1'b0, 1'b0)));
        chk_cnt();
        @(posedge clk); #1; reset = 1'b0;

        do_instr(6'b000000, 6'b100000, ADD, 0, 0);
        do_instr(6'b100011, 6'b000000, LW,  0, 3);
        do_instr(6'b000100, 6'b000000, BEQ, 0, 0);
        do_instr(6'b000101, 6'b000000, BNE, 1, 0);
        do_instr(6'b000011, 6'b000000, JAL, 0, 0);
        do_instr(6'b111111, 6'b000000, ILL, 0, 0);
        do_instr(6'b000000, 6'b100000, ADD, 2, 0);
        do_instr(6'b000000, 6'b100010, ILL, 0, 0);
        do_instr(6'b000010, 6'b000000, J,   0, 0);
        do_instr(6'b101011, 6'b000000, SW,  1, 2);

        // Reset in the middle of an sw that is waiting on memory
        op = 6'b101011; irfunc = '0;
        step(0, SW, 1'b1);
        step(1, SW, 1'b0);
        step(2, SW, 1'b0);
        step(3, SW, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rst_phase", 64'(phase), 64'd1);
        chk("rst_memWrite", 64'(memWrite), 64'd0);
        chk("rst_word", 64'(obs), 64'(expv(0, SW, 1'b0, 1'b0)));
        ret_m = 0; stall_m = 0;
        chk_cnt();
        @(posedge clk); #1; reset = 1'b0;

        do_instr(6'b000000, 6'b100000, ADD, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
